// File: rtl/mobo_pkg.sv
// Shared motherboard command/status codes and arbiter state encoding.
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

package mobo_pkg;

  localparam int unsigned MOBO_CMD_IDLE  = 0;
  localparam int unsigned MOBO_CMD_READ  = 1;
  localparam int unsigned MOBO_CMD_WRITE = 2;

  localparam int MOBO_STAT_BUSY_BIT = 0;
  localparam int MOBO_STAT_ACK_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mobo_arbiter_rr_pick.sv
// Two-way round-robin select: combinational one-hot pick plus the priority pointer.
module mobo_rr_pick (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  output logic [1:0] o_pick
);

  logic r_prio;

  always_comb begin
    o_pick = 2'b00;
    case (i_req)
      2'b01:   o_pick = 2'b01;
      2'b10:   o_pick = 2'b10;
      2'b11:   o_pick = r_prio ? 2'b10 : 2'b01;
      default: o_pick = 2'b00;
    endcase
  end

  // after serving requester n the other one gets priority
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prio <= 1'b0;
    end else if (i_adv && (|i_req)) begin
      r_prio <= o_pick[0];
    end
  end

endmodule

// File: rtl/mobo_arbiter.sv
// Arbitrates cpu/dma transactions onto the motherboard command/status port.
// state | meaning
// IDLE  | no transaction; grant the round-robin winner when any req is high
// ISSUE | one-cycle READ/WRITE command on mobo_ctrl, timeout counter cleared
// WAIT  | waiting for ACK or timeout
// DONE  | done (and err on timeout) pulse; gnt drops on exit
module mobo_arbiter
  import mobo_pkg::*;
#(
  parameter int word_width     = `WORD_WIDTH,
  parameter int timeout_cycles = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [1:0]            i_req,
  input  logic [1:0]            i_we,
  input  logic [word_width-1:0] i_addr0,
  input  logic [word_width-1:0] i_addr1,
  input  logic [word_width-1:0] i_wdata0,
  input  logic [word_width-1:0] i_wdata1,
  output logic [1:0]            o_gnt,
  output logic [1:0]            o_done,
  output logic [1:0]            o_err,
  output logic [word_width-1:0] o_rdata,
  output logic [word_width-1:0] o_mobo_ctrl,
  input  logic [word_width-1:0] i_mobo_stat,
  output logic [word_width-1:0] o_addr_out,
  output logic [word_width-1:0] o_mobodat_out,
  input  logic [word_width-1:0] i_mobodat_in
);

  localparam int CW = $clog2(timeout_cycles + 1);

  arb_state_t r_state, w_state_nxt;
  logic [1:0] r_gnt, w_gnt_nxt;
  logic [1:0] r_done, w_done_nxt;
  logic [1:0] r_err, w_err_nxt;
  logic r_we, w_we_nxt;
  logic [word_width-1:0] r_rdata, w_rdata_nxt;
  logic [word_width-1:0] r_ctrl, w_ctrl_nxt;
  logic [word_width-1:0] r_addr, w_addr_nxt;
  logic [word_width-1:0] r_wdata, w_wdata_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0] w_pick;
  logic w_adv;
  logic w_ack;
  logic w_unused_stat;

  assign w_ack = i_mobo_stat[MOBO_STAT_ACK_BIT];
  // BUSY is informational only; the handshake relies solely on ACK
  assign w_unused_stat = ^i_mobo_stat;

  mobo_rr_pick u_rr_pick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (i_req),
    .i_adv   (w_adv),
    .o_pick  (w_pick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = 2'b00;
    w_err_nxt   = 2'b00;
    w_we_nxt    = r_we;
    w_rdata_nxt = r_rdata;
    w_ctrl_nxt  = word_width'(MOBO_CMD_IDLE);
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_cnt_nxt   = r_cnt;
    w_adv       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|i_req) begin
          w_adv       = 1'b1;
          w_gnt_nxt   = w_pick;
          w_we_nxt    = w_pick[1] ? i_we[1] : i_we[0];
          w_addr_nxt  = w_pick[1] ? i_addr1 : i_addr0;
          w_wdata_nxt = w_pick[1] ? i_wdata1 : i_wdata0;
          w_ctrl_nxt  = w_we_nxt ? word_width'(MOBO_CMD_WRITE) : word_width'(MOBO_CMD_READ);
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_ack) begin
          if (!r_we) w_rdata_nxt = i_mobodat_in;
          w_done_nxt  = r_gnt;
          w_state_nxt = ST_DONE;
        end else if (r_cnt == CW'(timeout_cycles - 1)) begin
          w_cnt_nxt   = r_cnt + 1'b1;
          w_done_nxt  = r_gnt;
          w_err_nxt   = r_gnt;
          w_rdata_nxt = '0;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        w_gnt_nxt   = 2'b00;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= 2'b00;
      r_done  <= 2'b00;
      r_err   <= 2'b00;
      r_we    <= 1'b0;
      r_rdata <= '0;
      r_ctrl  <= word_width'(MOBO_CMD_IDLE);
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_we    <= w_we_nxt;
      r_rdata <= w_rdata_nxt;
      r_ctrl  <= w_ctrl_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_gnt         = r_gnt;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_rdata       = r_rdata;
  assign o_mobo_ctrl   = r_ctrl;
  assign o_addr_out    = r_addr;
  assign o_mobodat_out = r_wdata;

endmodule

// File: tb/tb_mobo_arbiter.sv
// Self-checking bench for mobo_arbiter: directed scenarios plus randomized transactions.
module tb_mobo_arbiter;
  import mobo_pkg::*;

  localparam int W = 16;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req, we;
  logic [W-1:0] addr0, addr1, wdata0, wdata1, mobo_stat, mobodat_in;
  logic [1:0]   gnt, done, err;
  logic [W-1:0] rdata, mobo_ctrl, addr_out, mobodat_out;

  int n_vec = 0;
  int n_err = 0;
  int prio = 0;
  logic [W-1:0] m_rdata = '0;

  mobo_arbiter #(.word_width(W), .timeout_cycles(T)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt(gnt), .o_done(done), .o_err(err), .o_rdata(rdata),
    .o_mobo_ctrl(mobo_ctrl), .i_mobo_stat(mobo_stat), .o_addr_out(addr_out),
    .o_mobodat_out(mobodat_out), .i_mobodat_in(mobodat_in)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_stat(input logic ack);
    mobo_stat = '0;
    mobo_stat[MOBO_STAT_ACK_BIT]  = ack;
    mobo_stat[MOBO_STAT_BUSY_BIT] = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk2({tag, "_gnt"}, gnt, 2'b00);
    chk2({tag, "_done"}, done, 2'b00);
    chk2({tag, "_err"}, err, 2'b00);
    chk({tag, "_rdata"}, rdata, '0);
    chk({tag, "_ctrl"}, mobo_ctrl, W'(MOBO_CMD_IDLE));
    chk({tag, "_addr"}, addr_out, '0);
    chk({tag, "_wdata"}, mobodat_out, '0);
  endtask

  // Called at a negedge in an idle cycle with req already set. d = WAIT cycle in which
  // ACK is given (beyond T means never); stray = ACK level during the ISSUE cycle.
  task automatic do_txn(input int d, input logic [W-1:0] rdat, input logic stray, input logic keep);
    int win;
    logic [1:0] oh;
    logic wr, tmo;
    logic [W-1:0] ea, ew;
    if (req == 2'b11) win = prio;
    else win = req[1] ? 1 : 0;
    prio = 1 - win;
    oh = (win == 1) ? 2'b10 : 2'b01;
    wr = we[win];
    ea = (win == 1) ? addr1 : addr0;
    ew = (win == 1) ? wdata1 : wdata0;
    tmo = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk2("gnt_issue", gnt, oh);
    chk("ctrl_issue", mobo_ctrl, wr ? W'(MOBO_CMD_WRITE) : W'(MOBO_CMD_READ));
    chk("addr_out", addr_out, ea);
    chk("mobodat_out", mobodat_out, ew);
    chk2("done_issue", done, 2'b00);
    set_stat(stray);
    mobodat_in = W'($urandom);
    for (int w = 1; w <= T; w++) begin
      @(negedge clk);
      chk2("gnt_wait", gnt, oh);
      chk("ctrl_wait", mobo_ctrl, W'(MOBO_CMD_IDLE));
      chk2("done_wait", done, 2'b00);
      set_stat(w == d);
      mobodat_in = (w == d) ? rdat : W'($urandom);
      if (w == d || w == T) begin
        tmo = (w != d);
        break;
      end
    end
    @(negedge clk);
    if (tmo) m_rdata = '0;
    else if (!wr) m_rdata = rdat;
    chk2("done_pulse", done, oh);
    chk2("err_pulse", err, tmo ? oh : 2'b00);
    chk("rdata_done", rdata, m_rdata);
    chk2("gnt_done", gnt, oh);
    chk("ctrl_done", mobo_ctrl, W'(MOBO_CMD_IDLE));
    set_stat(1'($urandom_range(0, 1)));
    if (!keep) req[win] = 1'b0;
    @(negedge clk);
    chk2("gnt_after", gnt, 2'b00);
    chk2("done_after", done, 2'b00);
    chk2("err_after", err, 2'b00);
    chk("rdata_hold", rdata, m_rdata);
    chk("addr_hold", addr_out, ea);
    chk("mobodat_hold", mobodat_out, ew);
    set_stat(1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    req = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mobo_stat = '0; mobodat_in = '0;
    #3;
    chk_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // both request writes straight out of reset: cpu first, then dma
    req = 2'b11; we = 2'b11;
    addr0 = 16'h0100; addr1 = 16'h0200; wdata0 = 16'h1111; wdata1 = 16'h2222;
    do_txn(1, 16'h0000, 1'b0, 1'b0);
    do_txn(2, 16'h0000, 1'b0, 1'b0);

    // cpu read, ACK on second WAIT cycle, stray ACK during ISSUE
    req = 2'b01; we = 2'b00; addr0 = 16'h0010; wdata0 = 16'h0000;
    do_txn(2, 16'h00AB, 1'b1, 1'b0);

    // no ACK at all: timeout
    req = 2'b01; we = 2'b00; addr0 = 16'h0020;
    do_txn(99, 16'h0000, 1'b0, 1'b0);

    // ACK exactly as the counter reaches the limit
    req = 2'b01; we = 2'b00; addr0 = 16'h0030;
    do_txn(T, 16'h5A5A, 1'b0, 1'b0);

    // dma holds req, cpu asks once: 1, 0, 1
    req = 2'b10; we = 2'b01; addr1 = 16'h0400; wdata1 = 16'h4444;
    do_txn(1, 16'h1234, 1'b0, 1'b1);
    req[0] = 1'b1; addr0 = 16'h0500; wdata0 = 16'h5555;
    do_txn(3, 16'h0000, 1'b0, 1'b0);
    do_txn(1, 16'h9876, 1'b0, 1'b0);

    // reset during WAIT
    req = 2'b01; we = 2'b00; addr0 = 16'h0033;
    prio = 1;
    @(posedge clk);
    @(negedge clk);
    chk2("gnt_pre_rst", gnt, 2'b01);
    @(negedge clk);
    set_stat(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    m_rdata = '0;
    prio = 0;
    @(negedge clk);
    chk2("done_in_rst", done, 2'b00);
    rst_n = 1'b1;
    req = 2'b11; we = 2'b00; addr0 = 16'h0044; addr1 = 16'h0055;
    do_txn(1, 16'hBEEF, 1'b0, 1'b0);
    do_txn(2, 16'hCAFE, 1'b0, 1'b0);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (!req[r] && ($urandom_range(0, 1) == 1)) begin
          req[r] = 1'b1;
          we[r] = 1'($urandom_range(0, 1));
          if (r == 0) begin addr0 = W'($urandom); wdata0 = W'($urandom); end
          else begin addr1 = W'($urandom); wdata1 = W'($urandom); end
        end
      end
      if (req == 2'b00) begin
        req[0] = 1'b1; we[0] = 1'($urandom_range(0, 1));
        addr0 = W'($urandom); wdata0 = W'($urandom);
      end
      set_stat(1'($urandom_range(0, 1)));
      do_txn(int'($urandom_range(1, T + 2)), W'($urandom), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0));
    end

    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk2("gnt_final", gnt, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
